utf8_stream_decoder: RTL and testbench

- Sits directly upstream of the terminal stream stage.
- Converts a raw byte stream (UART receiver output) into 21-bit Unicode code points, buffers them in a small FIFO, and presents them on the `unicode`/`unicode_available` pulse interface the terminal stage consumes.
- Paces output so the terminal stage only receives a code point while it is ready and has had time to finish its SDRAM cell writes.
- Provides byte-level flow control back to the receiver.

---
 rtl/utf8_stream_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_utf8_stream_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/utf8_stream_decoder.sv
// UTF-8 byte stream to 21-bit code point decoder with output FIFO and paced strobe interface.
// Optional build macro UTF8_STRICT_EN: overlong, surrogate and out-of-range sequences decode to U+FFFD.
//
// state | meaning
// IDLE  | waiting for a lead byte (or processing a replayed byte)
// NEED1 | one continuation byte still expected
// NEED2 | two continuation bytes still expected
// NEED3 | three continuation bytes still expected
module utf8_stream_decoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_available,
  output logic        in_ready,
  output logic [20:0] unicode,
  output logic        unicode_available,
  input  logic        ready_n,
  output logic        overflow,
  output logic [4:0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  GAP_LOAD   = 8'(GAP_CYCLES);
  localparam logic [20:0] REPL_CHAR  = 21'h00FFFD;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NEED1 = 2'd1;
  localparam logic [1:0] S_NEED2 = 2'd2;
  localparam logic [1:0] S_NEED3 = 2'd3;

  logic [1:0]    state, nxt_state;
  logic [20:0]   acc, nxt_acc;
  logic [20:0]   acc_shift;
  logic [20:0]   done_val;
  logic          replay_pending;
  logic [7:0]    replay_byte;
  logic          set_replay;

  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    gap_cnt;

  logic          fifo_full, fifo_empty;
  logic          byte_take, proc_valid;
  logic [7:0]    cur_byte;
  logic [1:0]    cur_state;
  logic          push, push_ok, emit, byte_drop;
  logic [20:0]   push_data;

  assign fifo_full  = (level == LEVEL_FULL);
  assign fifo_empty = (level == '0);
  assign in_ready   = !reset && !fifo_full && !replay_pending;
  assign byte_take  = in_available && in_ready;
  assign byte_drop  = in_available && !in_ready && !replay_pending;

  // A replayed byte always re-enters the decoder as a fresh lead byte.
  assign proc_valid = byte_take || replay_pending;
  assign cur_byte   = replay_pending ? replay_byte : in_byte;
  assign cur_state  = replay_pending ? S_IDLE : state;

  assign acc_shift  = (acc << 6) | {15'd0, cur_byte[5:0]};

`ifdef UTF8_STRICT_EN
  logic [1:0] len, nxt_len;
  logic       strict_bad;

  always_comb begin
    strict_bad = 1'b0;
    if ((len == 2'd1) && (acc_shift < 21'h000080)) strict_bad = 1'b1;
    if ((len == 2'd2) && (acc_shift < 21'h000800)) strict_bad = 1'b1;
    if ((len == 2'd3) && (acc_shift < 21'h010000)) strict_bad = 1'b1;
    if ((acc_shift >= 21'h00D800) && (acc_shift <= 21'h00DFFF)) strict_bad = 1'b1;
    if (acc_shift > 21'h10FFFF) strict_bad = 1'b1;
  end

  assign done_val = strict_bad ? REPL_CHAR : acc_shift;
`else
  assign done_val = acc_shift;
`endif

  always_comb begin
    nxt_state  = state;
    nxt_acc    = acc;
    push       = 1'b0;
    push_data  = '0;
    set_replay = 1'b0;
`ifdef UTF8_STRICT_EN
    nxt_len    = len;
`endif
    if (proc_valid) begin
      if (cur_state == S_IDLE) begin
        casez (cur_byte)
          8'b0???????: begin
            push      = 1'b1;
            push_data = {13'd0, cur_byte};
          end
          8'b110?????: begin
            nxt_acc   = {16'd0, cur_byte[4:0]};
            nxt_state = S_NEED1;
`ifdef UTF8_STRICT_EN
            nxt_len   = 2'd1;
`endif
          end
          8'b1110????: begin
            nxt_acc   = {17'd0, cur_byte[3:0]};
            nxt_state = S_NEED2;
`ifdef UTF8_STRICT_EN
            nxt_len   = 2'd2;
`endif
          end
          8'b11110???: begin
            nxt_acc   = {18'd0, cur_byte[2:0]};
            nxt_state = S_NEED3;
`ifdef UTF8_STRICT_EN
            nxt_len   = 2'd3;
`endif
          end
          default: begin
            push      = 1'b1;
            push_data = REPL_CHAR;
          end
        endcase
      end else if (cur_byte[7:6] == 2'b10) begin
        if (cur_state == S_NEED1) begin
          push      = 1'b1;
          push_data = done_val;
          nxt_state = S_IDLE;
        end else begin
          nxt_acc   = acc_shift;
          nxt_state = cur_state - 2'd1;
        end
      end else begin
        // Broken sequence: report it, then decode the offending byte next cycle.
        push       = 1'b1;
        push_data  = REPL_CHAR;
        set_replay = 1'b1;
        nxt_state  = S_IDLE;
      end
    end
  end

  assign push_ok = push && !fifo_full;
  // gap_cnt reaches zero on the edge that registers the next strobe, so strobes land GAP_CYCLES apart.
  assign emit    = !fifo_empty && !ready_n && (gap_cnt <= 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      acc               <= '0;
      replay_pending    <= 1'b0;
      replay_byte       <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      gap_cnt           <= '0;
      overflow          <= 1'b0;
      unicode           <= '0;
      unicode_available <= 1'b0;
`ifdef UTF8_STRICT_EN
      len               <= '0;
`endif
    end else begin
      state          <= nxt_state;
      acc            <= nxt_acc;
      replay_pending <= set_replay;
      if (set_replay) replay_byte <= cur_byte;
`ifdef UTF8_STRICT_EN
      len            <= nxt_len;
`endif

      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end

      unicode_available <= emit;
      if (emit) begin
        unicode <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      case ({push_ok, emit})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (byte_drop || (push && fifo_full)) overflow <= 1'b1;
    end
  end

  assign fifo_level = 5'(level);

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Directed bench for utf8_stream_decoder: vector table plus hand sequences for replay, overflow and reset.
module tb_utf8_stream_decoder;

  localparam int GAP   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_available = 1'b0;
  logic        in_ready;
  logic [20:0] unicode;
  logic        unicode_available;
  logic        ready_n = 1'b0;
  logic        overflow;
  logic [4:0]  fifo_level;

  utf8_stream_decoder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_available(in_available),
    .in_ready(in_ready), .unicode(unicode), .unicode_available(unicode_available),
    .ready_n(ready_n), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [20:0] got_q[$];
  int          got_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && unicode_available) begin
      got_q.push_back(unicode);
      got_t.push_back(cyc);
    end
  end

  typedef struct packed {
    logic [3:0][7:0]  b;
    logic [2:0]       nb;
    logic [1:0][20:0] e;
    logic [1:0]       ne;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [7:0] b0, b1, b2, b3,
                              input int ne, input logic [20:0] e0, e1);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.nb = 3'(nb);
    v.e[0] = e0; v.e[1] = e1;
    v.ne = 2'(ne);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    in_byte = b;
    in_available = 1'b1;
    tick();
    in_available = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    strobe_byte(b);
  endtask

  task automatic wait_strobes(input int n, input string name);
    int w = 0;
    while (got_q.size() < n && w < 300) begin
      tick();
      w++;
    end
    for (int i = 0; i < 3 * GAP; i++) tick();
    check({name, "_count"}, got_q.size(), n);
  endtask

  task automatic clear_capture;
    got_q.delete();
    got_t.delete();
  endtask

  vec_t vt[13];
  int   t0;

  initial begin
    vt[0]  = mk(1, 8'h41, 8'h00, 8'h00, 8'h00, 1, 21'h000041, 21'h0);
    vt[1]  = mk(2, 8'hC3, 8'hA9, 8'h00, 8'h00, 1, 21'h0000E9, 21'h0);
    vt[2]  = mk(3, 8'hE2, 8'h82, 8'hAC, 8'h00, 1, 21'h0020AC, 21'h0);
    vt[3]  = mk(4, 8'hF0, 8'h9F, 8'h98, 8'h80, 1, 21'h01F600, 21'h0);
    vt[4]  = mk(1, 8'h80, 8'h00, 8'h00, 8'h00, 1, 21'h00FFFD, 21'h0);
    vt[5]  = mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 21'h00FFFD, 21'h0);
    vt[6]  = mk(2, 8'hE2, 8'h41, 8'h00, 8'h00, 2, 21'h00FFFD, 21'h000041);
    vt[7]  = mk(3, 8'hC3, 8'hC3, 8'hA9, 8'h00, 2, 21'h00FFFD, 21'h0000E9);
    vt[8]  = mk(1, 8'h7F, 8'h00, 8'h00, 8'h00, 1, 21'h00007F, 21'h0);
    vt[9]  = mk(2, 8'hDF, 8'hBF, 8'h00, 8'h00, 1, 21'h0007FF, 21'h0);
`ifdef UTF8_STRICT_EN
    vt[10] = mk(2, 8'hC0, 8'h80, 8'h00, 8'h00, 1, 21'h00FFFD, 21'h0);
    vt[11] = mk(3, 8'hED, 8'hA0, 8'h80, 8'h00, 1, 21'h00FFFD, 21'h0);
    vt[12] = mk(4, 8'hF4, 8'h90, 8'h80, 8'h80, 1, 21'h00FFFD, 21'h0);
`else
    vt[10] = mk(2, 8'hC0, 8'h80, 8'h00, 8'h00, 1, 21'h000000, 21'h0);
    vt[11] = mk(3, 8'hED, 8'hA0, 8'h80, 8'h00, 1, 21'h00D800, 21'h0);
    vt[12] = mk(4, 8'hF4, 8'h90, 8'h80, 8'h80, 1, 21'h110000, 21'h0);
`endif

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_avail", {31'd0, unicode_available}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_unicode", {11'd0, unicode}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Pacing and latency
    clear_capture();
    t0 = cyc;
    strobe_byte(8'h41);
    strobe_byte(8'h0A);
    wait_strobes(2, "pace");
    check("pace_first", {11'd0, got_q[0]}, 32'h41);
    check("pace_second", {11'd0, got_q[1]}, 32'h0A);
    check("pace_latency", got_t[0] - t0, 32'd2);
    check("pace_gap", got_t[1] - got_t[0], GAP);
    check("pace_level", {27'd0, fifo_level}, 32'd0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      clear_capture();
      for (int j = 0; j < int'(vt[i].nb); j++) send_byte(vt[i].b[j]);
      wait_strobes(int'(vt[i].ne), $sformatf("vec%0d", i));
      for (int k = 0; k < int'(vt[i].ne); k++)
        check($sformatf("vec%0d_cp%0d", i, k), {11'd0, got_q[k]}, {11'd0, vt[i].e[k]});
    end

    // Replay stall timing
    clear_capture();
    send_byte(8'hE2);
    strobe_byte(8'h41);
    check("replay_stall", {31'd0, in_ready}, 32'd0);
    tick();
    check("replay_release", {31'd0, in_ready}, 32'd1);
    wait_strobes(2, "replay");
    check("replay_cp0", {11'd0, got_q[0]}, 32'hFFFD);
    check("replay_cp1", {11'd0, got_q[1]}, 32'h41);
    check("replay_overflow", {31'd0, overflow}, 32'd0);

    // FIFO fill, drop and drain
    clear_capture();
    ready_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) strobe_byte(8'(8'h41 + i));
    check("full_level", {27'd0, fifo_level}, DEPTH);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_no_ovf_yet", {31'd0, overflow}, 32'd0);
    strobe_byte(8'h51);
    check("drop_overflow", {31'd0, overflow}, 32'd1);
    check("drop_level", {27'd0, fifo_level}, DEPTH);
    ready_n = 1'b0;
    wait_strobes(DEPTH, "drain");
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("drain_cp%0d", i), {11'd0, got_q[i]}, 32'(8'h41 + i));
    check("drain_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-sequence discards the partial code point
    send_byte(8'hF0);
    send_byte(8'h9F);
    clear_capture();
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("mid_rst_unicode", {11'd0, unicode}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    tick();
    send_byte(8'h41);
    wait_strobes(1, "post_rst");
    check("post_rst_cp", {11'd0, got_q[0]}, 32'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
